// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - fetch-to-decode instruction queue with first-word-fall-through head
// Define IRQ_BYPASS_EN for a zero-latency empty-queue path from fetch to decode.
module ir_queue #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_inst,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_inst,
    output logic [PC_W-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W+PC_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wp, rp;
    logic                   push, pop, bypass, wr_en, rd_en;

    always_comb begin
        full     = (count == FULL_CNT);
        empty    = (count == '0);
        in_ready = !full;
        push     = in_valid && in_ready;
`ifdef IRQ_BYPASS_EN
        bypass   = empty && !flush && !rst && in_valid;
`else
        bypass   = 1'b0;
`endif
        out_valid = !empty || bypass;
        pop       = out_valid && out_ready;
        // A bypassed instruction taken by decode in the same cycle never touches storage.
        wr_en     = push && !(bypass && out_ready);
        rd_en     = pop && !empty;
        if (!empty) begin
            out_inst = mem[rp][DATA_W+PC_W-1:PC_W];
            out_pc   = mem[rp][PC_W-1:0];
        end else if (bypass) begin
            out_inst = in_inst;
            out_pc   = in_pc;
        end else begin
            out_inst = '0;
            out_pc   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_en) wp <= wp + AW'(1);
            if (rd_en) rp <= rp + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_en) mem[wp] <= {in_inst, in_pc};
    end
endmodule
